// File: rtl/double_cmp_sched_if.sv
// Requester-side bundle of the shared compare scheduler: packed per-requester
// request operands and grants, plus the returned result pulse.
interface double_cmp_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OP_W    = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [64*NUM_REQ-1:0]   req_a;
    logic [64*NUM_REQ-1:0]   req_b;
    logic [OP_W*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic                    rsp_z;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_z
    );
endinterface

// File: rtl/double_cmp_sched.sv
// Round-robin scheduler sharing one pipelined double compare unit between
// NUM_REQ requesters; routes each result back to its issuer via a tag pipeline.
module double_cmp_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CMP_LATENCY = 1,
    parameter int unsigned OP_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    double_cmp_sched_if.slave       req_bus,
    output logic                    cmp_valid,
    output logic [63:0]             cmp_a,
    output logic [63:0]             cmp_b,
    output logic [OP_W-1:0]         cmp_op,
    input  logic                    cmp_z,
    output logic                    busy
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH  = CMP_LATENCY + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id_c;
    logic               grant_any_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    ptr_next_c;

    logic [DEPTH-1:0]   tag_vld;
    logic [ID_W-1:0]    tag_id [DEPTH];

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_z_q;

    // First valid requester at or after the pointer, wrapping; gated off in reset.
    always_comb begin : arb
        int unsigned idx;
        idx         = 0;
        grant_c     = '0;
        grant_id_c  = '0;
        grant_any_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (rst_n && !grant_any_c && req_bus.req_valid[ID_W'(idx)]) begin
                grant_any_c              = 1'b1;
                grant_id_c               = ID_W'(idx);
                grant_c[ID_W'(idx)]      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next_c = grant_id_c + ID_W'(1);
        if (grant_id_c == ID_W'(NUM_REQ - 1)) begin
            ptr_next_c = '0;
        end
    end

    assign req_bus.req_ready = grant_c;
    assign req_bus.rsp_valid = rsp_valid_q;
    assign req_bus.rsp_z     = rsp_z_q;
    assign busy              = (|tag_vld) | cmp_valid;

    // Issue register, tag shift pipeline and response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cmp_valid   <= 1'b0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            cmp_op      <= '0;
            tag_vld     <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_id[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_z_q     <= 1'b0;
        end else begin
            cmp_valid <= grant_any_c;
            if (grant_any_c) begin
                rr_ptr <= ptr_next_c;
                cmp_a  <= req_bus.req_a[DATA_W*grant_id_c +: DATA_W];
                cmp_b  <= req_bus.req_b[DATA_W*grant_id_c +: DATA_W];
                cmp_op <= req_bus.req_op[OP_W*grant_id_c +: OP_W];
            end

            // Slot k holds the op issued k+1 cycles ago; the last slot lines up with cmp_z.
            tag_vld   <= {tag_vld[DEPTH-2:0], grant_any_c};
            tag_id[0] <= grant_id_c;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            rsp_valid_q <= tag_vld[DEPTH-1] ? (NUM_REQ'(1) << tag_id[DEPTH-1]) : '0;
            if (tag_vld[DEPTH-1]) begin
                rsp_z_q <= cmp_z;
            end
        end
    end
endmodule
